demux_8bits_router: RTL and testbench
=====================================

# demux_8bits_router

Registered 1-to-4 byte router that is the inverse of the team's 8-bit 4-to-1 mux tree. It takes one byte stream and steers each accepted byte to one of four output channels a/b/c/d. Channel choice uses the same three select bits, with the same polarity, that the mux tree uses to pick its source. Each output channel has a one-entry holding register with a valid/ready handshake, so a stalled channel does not corrupt data on the other channels.

## Interface
Parameters:
- WIDTH, 8, data width of input and every output channel
- CNT_W, 8, width of each per-channel transfer counter

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_data  in  WIDTH  byte to route
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  router accepts in_data this cycle
- sel1  in  1  within group a/b: 1 selects a, 0 selects b
- sel2  in  1  within group c/d: 1 selects c, 0 selects d
- sel3  in  1  group select: 1 selects group a/b, 0 selects group c/d
- a, b, c, d  out  WIDTH each  channel data outputs (registered)
- a_valid, b_valid, c_valid, d_valid  out  1 each  channel holds a byte
- a_ready, b_ready, c_ready, d_ready  in  1 each  downstream takes the held byte
- cnt_a, cnt_b, cnt_c, cnt_d  out  CNT_W each  saturating count of bytes delivered per channel

## Operation
- Target channel t is decoded combinationally:
  - sel3=1, sel1=1 → a
  - sel3=1, sel1=0 → b
  - sel3=0, sel2=1 → c
  - sel3=0, sel2=0 → d
  - Select bits that do not apply to the current group are ignored.
- in_ready = !t_valid | t_ready. This is combinational from the select bits and the target channel's ready only. It does not depend on in_valid.
- Accept = in_valid & in_ready. On accept, t's register loads in_data and t_valid = 1 on the next cycle.
- Channel drain = x_valid & x_ready. On drain, x_valid clears next cycle, unless the same channel is loaded in the same cycle; then valid stays 1 and the data updates.
- While x_valid=1 and x_ready=0, the channel data and valid stay stable.
- Non-target channels drain independently in the same cycle as an accept into t.
- cnt_x increments by 1 on each drain of channel x. It saturates at 2^CNT_W−1 and does not wrap.
- Select bits are sampled only at acceptance. They may change freely while in_valid is held with in_ready=0, and the byte goes to whatever target applies in the cycle it is accepted.

## Timing
- Reset, synchronous: on the first rising edge with rst=1:
  - a/b/c/d = 0
  - all x_valid = 0
  - all cnt_x = 0
- in_ready is 1 during and after reset, because all channels are empty. Accepts in a cycle with rst=1 are discarded.
- Latency: a byte accepted at edge n appears on the target output with valid=1 after edge n (cycle n+1).
- Throughput: 1 byte/cycle into a single channel whose ready is held at 1. Bytes can also go to different channels on alternate cycles at full rate.
- Reset asserted mid-operation drops all held bytes. Counters clear, and no partial state survives.
- Counter update occurs on the same edge that clears or reloads the channel valid.

## Structure
- Shared package:
  - channel index constants CH_A=0, CH_B=1, CH_C=2, CH_D=3
  - decode function (sel1, sel2, sel3) → channel index, reused by the bench scoreboard
  - default WIDTH and CNT_W
- Sub-module demux_slot, instantiated 4 times:
  - one-entry holding register with load/data/valid/ready and a saturating drain counter
  - exposes ready_to_load = !valid | ready
- Top level contains only the select decode, the in_ready mux, and the per-slot load enables.

## Test plan
- Reset, then route 0x11 with sel3=1, sel1=1, with all readies 1 → a=0x11, a_valid=1 for one cycle at n+1, cnt_a=1. Other channels stay valid=0 with data 0.
- Sweep the four select codes with 0xA0..0xA3 on consecutive cycles, all readies 1 → a=0xA0, b=0xA1, c=0xA2, d=0xA3, each exactly one cycle after accept. Each counter = 1.
- Stall: c_ready=0, send 0x55 to c, then 0x66 to c → 0x55 held stable and in_ready=0 while sel targets c. Raise c_ready → 0x66 loads in the same cycle 0x55 drains, c_valid stays 1, cnt_c=2.
- Blocked target, other channels free: d full with d_ready=0, in_valid held, sel moved from d to a → in_ready rises and the byte lands on a, not d.
- Saturation: 300 drains on b with CNT_W=8 → cnt_b=255.
- Reset mid-stream: with a and c holding bytes, assert rst for one cycle → all valids 0, data 0, counters 0. The next accept behaves as after the first reset.

Source files
------------

// File: rtl/demux_8bits_router_pkg.sv
// Shared definitions for the 1-to-4 byte router: channel indices, default
// widths and the select-bit decode used by both the RTL and the bench.
package demux_8bits_router_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 8;
  localparam int NUM_CH        = 4;

  typedef enum logic [1:0] {
    CH_A = 2'd0,
    CH_B = 2'd1,
    CH_C = 2'd2,
    CH_D = 2'd3
  } ch_e;

  // Same polarity as the 4-to-1 mux tree: sel3 picks the group, and then
  // sel1 or sel2 picks within it. The select bit of the other group is ignored.
  function automatic ch_e decode_target(input logic sel1, input logic sel2,
                                        input logic sel3);
    if (sel3) return sel1 ? CH_A : CH_B;
    else      return sel2 ? CH_C : CH_D;
  endfunction

endpackage

// File: rtl/demux_8bits_router_slot.sv
// One-entry output holding register with a valid/ready handshake and a
// saturating count of bytes drained downstream.
module demux_slot
  import demux_8bits_router_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic [CNT_W-1:0] cnt,
  output logic             ready_to_load
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             drain;

  // NOTE: every signal gets a default before any condition, so no latch is inferred.
  always_comb begin
    drain   = valid_q & ready;
    data_d  = data_q;
    valid_d = valid_q & ~ready;
    cnt_d   = cnt_q;
    if (load) begin
      data_d  = load_data;
      valid_d = 1'b1;
    end
    if (drain && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state uses non-blocking assignments. The data register is reset as
  // well, because the zero reset value is visible on the output port.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data          = data_q;
  assign valid         = valid_q;
  assign cnt           = cnt_q;
  assign ready_to_load = ~valid_q | ready;

endmodule

// File: rtl/demux_8bits_router.sv
// Registered 1-to-4 byte router: decodes the target channel from the select
// bits and loads the accepted byte into that channel's holding slot.
module demux_8bits_router
  import demux_8bits_router_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  input  logic             sel3,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] d,
  output logic             a_valid,
  output logic             b_valid,
  output logic             c_valid,
  output logic             d_valid,
  input  logic             a_ready,
  input  logic             b_ready,
  input  logic             c_ready,
  input  logic             d_ready,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c,
  output logic [CNT_W-1:0] cnt_d
);

  ch_e               target;
  logic [NUM_CH-1:0] slot_ready;
  logic [NUM_CH-1:0] slot_rtl;
  logic [NUM_CH-1:0] slot_valid;
  logic [NUM_CH-1:0] slot_load;
  logic [WIDTH-1:0]  slot_data [NUM_CH];
  logic [CNT_W-1:0]  slot_cnt  [NUM_CH];

  assign slot_ready = {d_ready, c_ready, b_ready, a_ready};

  // in_ready looks only at the decoded target, never at in_valid.
  always_comb begin
    target    = decode_target(sel1, sel2, sel3);
    in_ready  = slot_rtl[target];
    slot_load = '0;
    if (in_valid && in_ready) slot_load[target] = 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
    demux_slot #(
      .WIDTH(WIDTH),
      .CNT_W(CNT_W)
    ) u_slot (
      .clk          (clk),
      .rst          (rst),
      .load         (slot_load[i]),
      .load_data    (in_data),
      .ready        (slot_ready[i]),
      .data         (slot_data[i]),
      .valid        (slot_valid[i]),
      .cnt          (slot_cnt[i]),
      .ready_to_load(slot_rtl[i])
    );
  end

  assign a       = slot_data[CH_A];
  assign b       = slot_data[CH_B];
  assign c       = slot_data[CH_C];
  assign d       = slot_data[CH_D];
  assign a_valid = slot_valid[CH_A];
  assign b_valid = slot_valid[CH_B];
  assign c_valid = slot_valid[CH_C];
  assign d_valid = slot_valid[CH_D];
  assign cnt_a   = slot_cnt[CH_A];
  assign cnt_b   = slot_cnt[CH_B];
  assign cnt_c   = slot_cnt[CH_C];
  assign cnt_d   = slot_cnt[CH_D];

endmodule

// File: tb/tb_demux_8bits_router.sv
// Bench for demux_8bits_router: a per-cycle scoreboard model plus directed
// scenarios with literal expectations.
module tb_demux_8bits_router;
  import demux_8bits_router_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 8;
  localparam int SAT = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          sel1, sel2, sel3;
  logic [W-1:0]  a, b, c, d;
  logic          a_valid, b_valid, c_valid, d_valid;
  logic          a_ready, b_ready, c_ready, d_ready;
  logic [CW-1:0] cnt_a, cnt_b, cnt_c, cnt_d;

  demux_8bits_router #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .sel1(sel1), .sel2(sel2), .sel3(sel3),
    .a(a), .b(b), .c(c), .d(d),
    .a_valid(a_valid), .b_valid(b_valid), .c_valid(c_valid), .d_valid(d_valid),
    .a_ready(a_ready), .b_ready(b_ready), .c_ready(c_ready), .d_ready(d_ready),
    .cnt_a(cnt_a), .cnt_b(cnt_b), .cnt_c(cnt_c), .cnt_d(cnt_d)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // DUT outputs gathered by channel index for the scoreboard.
  logic [W-1:0]  dut_data  [4];
  logic          dut_valid [4];
  logic [CW-1:0] dut_cnt   [4];
  logic [3:0]    rdy_v;
  always_comb begin
    dut_data  = '{a, b, c, d};
    dut_valid = '{a_valid, b_valid, c_valid, d_valid};
    dut_cnt   = '{cnt_a, cnt_b, cnt_c, cnt_d};
    rdy_v     = {d_ready, c_ready, b_ready, a_ready};
  end

  // Behavioural model: one byte slot per channel and an integer drain count.
  logic [W-1:0] m_data  [4];
  logic         m_valid [4];
  int           m_cnt   [4];
  bit           m_live = 1'b0;
  int           m_tgt;
  logic         m_rdy;

  always_comb begin
    m_tgt = int'(decode_target(sel1, sel2, sel3));
    m_rdy = !m_valid[m_tgt] || rdy_v[m_tgt];
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        m_data[i]  <= '0;
        m_valid[i] <= 1'b0;
        m_cnt[i]   <= 0;
      end
      m_live <= 1'b1;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (in_valid && m_rdy && m_tgt == i) begin
          m_data[i]  <= in_data;
          m_valid[i] <= 1'b1;
        end else if (m_valid[i] && rdy_v[i]) begin
          m_valid[i] <= 1'b0;
        end
        if (m_valid[i] && rdy_v[i] && m_cnt[i] < SAT) m_cnt[i] <= m_cnt[i] + 1;
      end
    end
  end

  // Compare process: sample on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("sb_data[%0d]", i),  32'(dut_data[i]),  32'(m_data[i]));
        check($sformatf("sb_valid[%0d]", i), 32'(dut_valid[i]), 32'(m_valid[i]));
        check($sformatf("sb_cnt[%0d]", i),   32'(dut_cnt[i]),   32'(m_cnt[i]));
      end
      check("sb_in_ready", 32'(in_ready), 32'(m_rdy));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives the select bits for channel ch (0=a .. 3=d); irrelevant bits get random values.
  task automatic set_sel(input int ch);
    case (ch)
      0:       begin sel3 = 1'b1; sel1 = 1'b1; sel2 = 1'($urandom_range(0, 1)); end
      1:       begin sel3 = 1'b1; sel1 = 1'b0; sel2 = 1'($urandom_range(0, 1)); end
      2:       begin sel3 = 1'b0; sel2 = 1'b1; sel1 = 1'($urandom_range(0, 1)); end
      default: begin sel3 = 1'b0; sel2 = 1'b0; sel1 = 1'($urandom_range(0, 1)); end
    endcase
  endtask

  task automatic send(input int ch, input logic [W-1:0] val);
    set_sel(ch);
    in_data  = val;
    in_valid = 1'b1;
    step();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hEE;
    set_sel(0);
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    sel1 = 1'b0; sel2 = 1'b0; sel3 = 1'b0;
    a_ready = 1'b1; b_ready = 1'b1; c_ready = 1'b1; d_ready = 1'b1;
    step();
    do_reset();

    // Reset state, then a single byte to a.
    check("rst_a_valid", 32'(a_valid), 0);
    check("rst_d_data",  32'(d), 0);
    check("rst_cnt_c",   32'(cnt_c), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    send(0, 8'h11);
    in_valid = 1'b0;
    check("t1_a", 32'(a), 32'h11);
    check("t1_a_valid", 32'(a_valid), 1);
    check("t1_b_valid", 32'(b_valid), 0);
    step();
    check("t1_a_drained", 32'(a_valid), 0);
    check("t1_cnt_a", 32'(cnt_a), 1);
    check("t1_c_data", 32'(c), 0);

    // Sweep all four codes back to back.
    do_reset();
    send(0, 8'hA0);
    check("sw_a", 32'(a), 32'hA0);
    check("sw_a_valid", 32'(a_valid), 1);
    send(1, 8'hA1);
    check("sw_b", 32'(b), 32'hA1);
    check("sw_a_gone", 32'(a_valid), 0);
    send(2, 8'hA2);
    check("sw_c", 32'(c), 32'hA2);
    send(3, 8'hA3);
    check("sw_d", 32'(d), 32'hA3);
    check("sw_d_valid", 32'(d_valid), 1);
    in_valid = 1'b0;
    step();
    check("sw_cnt_a", 32'(cnt_a), 1);
    check("sw_cnt_b", 32'(cnt_b), 1);
    check("sw_cnt_c", 32'(cnt_c), 1);
    check("sw_cnt_d", 32'(cnt_d), 1);

    // Stall on c, then reload in the same cycle that the held byte drains.
    do_reset();
    c_ready = 1'b0;
    send(2, 8'h55);
    in_data = 8'h66;
    #1 check("st_in_ready_lo", 32'(in_ready), 0);
    step();
    check("st_c_held", 32'(c), 32'h55);
    check("st_c_valid", 32'(c_valid), 1);
    c_ready = 1'b1;
    #1 check("st_in_ready_hi", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("st_c_reload", 32'(c), 32'h66);
    check("st_c_valid2", 32'(c_valid), 1);
    check("st_cnt_c1", 32'(cnt_c), 1);
    step();
    check("st_cnt_c2", 32'(cnt_c), 2);
    check("st_c_empty", 32'(c_valid), 0);

    // d is blocked; moving the select to a lets the byte go to a.
    do_reset();
    d_ready = 1'b0;
    send(3, 8'h77);
    in_data = 8'h88;
    #1 check("bl_in_ready_lo", 32'(in_ready), 0);
    step();
    check("bl_d_held", 32'(d), 32'h77);
    check("bl_a_empty", 32'(a_valid), 0);
    set_sel(0);
    #1 check("bl_in_ready_hi", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("bl_a", 32'(a), 32'h88);
    check("bl_a_valid", 32'(a_valid), 1);
    check("bl_d_still", 32'(d), 32'h77);
    d_ready = 1'b1;
    step();

    // Counter saturation on b.
    do_reset();
    for (int i = 0; i < 300; i++) send(1, 8'(i));
    in_valid = 1'b0;
    step();
    step();
    check("sat_cnt_b", 32'(cnt_b), 255);

    // Reset in mid-stream with a and c still holding bytes.
    do_reset();
    a_ready = 1'b0; c_ready = 1'b0;
    send(0, 8'h12);
    send(2, 8'h34);
    in_valid = 1'b0;
    check("mr_a_held", 32'(a_valid), 1);
    check("mr_c_held", 32'(c_valid), 1);
    a_ready = 1'b1; c_ready = 1'b1;
    do_reset();
    check("mr_a_valid", 32'(a_valid), 0);
    check("mr_c_valid", 32'(c_valid), 0);
    check("mr_a_data", 32'(a), 0);
    check("mr_c_data", 32'(c), 0);
    check("mr_cnt_b", 32'(cnt_b), 0);
    send(0, 8'h11);
    in_valid = 1'b0;
    check("mr_t1_a", 32'(a), 32'h11);
    step();
    check("mr_t1_cnt_a", 32'(cnt_a), 1);

    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
